// File: rtl/arb_merge4_rr_sched.sv
// Round-robin scheduler that shares one downstream micropipeline stage among
// NREQ pulse-driven requesters, with overflow, spurious-free and watchdog flags.
module arb_merge4_rr_sched #(
  parameter int NREQ    = 4,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            w_rstStartflag,
  input  logic [NREQ-1:0] i_drive,
  output logic [NREQ-1:0] o_free,
  output logic            o_driveNext,
  input  logic            i_freeNext,
  output logic [NREQ-1:0] o_validation,
  input  logic            i_stopStartFlag,
  output logic [NREQ-1:0] o_pending,
  output logic            o_overflow,
  output logic            o_spurious,
  output logic            o_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_FREE = 2'd2
  } stateT;

  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

  stateT            stateR;
  logic [PTR_W-1:0] ptrR;
  logic [PTR_W-1:0] selR;
  logic [NREQ-1:0]  pendingR;
  logic [NREQ-1:0]  validR;
  logic [NREQ-1:0]  freeR;
  logic             driveR;
  logic [TO_W-1:0]  cntR;
  logic             overflowR;
  logic             spuriousR;
  logic             timeoutR;

  logic             freeEvtS;
  logic [NREQ-1:0]  clrMaskS;
  logic [NREQ-1:0]  dropMaskS;
  logic [NREQ-1:0]  pendingNextS;
  logic [PTR_W-1:0] grantSelS;
  logic [TO_W-1:0]  cntIncS;
  logic [PTR_W-1:0] ptrNextS;

  // First set bit at or after base, searching upward modulo NREQ; the lowest
  // offset wins because it is visited last.
  function automatic logic [PTR_W-1:0] pickNext(input logic [NREQ-1:0] req,
                                                input logic [PTR_W-1:0] base);
    logic [PTR_W-1:0] pick;
    int idx;
    pick = base;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = (int'(base) + off) % NREQ;
      if (req[idx]) begin
        pick = PTR_W'(idx);
      end
    end
    return pick;
  endfunction

  // Pending bookkeeping, arbitration choice, watchdog increment and pointer advance.
  always_comb begin
    freeEvtS     = (stateR == WAIT_FREE) && i_freeNext;
    clrMaskS     = freeEvtS ? validR : {NREQ{1'b0}};
    dropMaskS    = i_drive & pendingR & ~clrMaskS;
    pendingNextS = (pendingR & ~clrMaskS) | i_drive;
    grantSelS    = pickNext(pendingR, ptrR);
    cntIncS      = (cntR == {TO_W{1'b1}}) ? cntR : cntR + TO_W'(1);
    ptrNextS     = (selR == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}} : selR + PTR_W'(1);
  end

  // Scheduler FSM with all outputs registered; sticky flags clear only on reset.
  always_ff @(posedge clk or negedge w_rstStartflag) begin
    if (!w_rstStartflag) begin
      stateR    <= IDLE;
      ptrR      <= {PTR_W{1'b0}};
      selR      <= {PTR_W{1'b0}};
      pendingR  <= {NREQ{1'b0}};
      validR    <= {NREQ{1'b0}};
      freeR     <= {NREQ{1'b0}};
      driveR    <= 1'b0;
      cntR      <= {TO_W{1'b0}};
      overflowR <= 1'b0;
      spuriousR <= 1'b0;
      timeoutR  <= 1'b0;
    end else begin
      pendingR <= pendingNextS;
      freeR    <= {NREQ{1'b0}};
      driveR   <= 1'b0;
      if (|dropMaskS) begin
        overflowR <= 1'b1;
      end
      case (stateR)
        IDLE: begin
          if (i_freeNext) begin
            spuriousR <= 1'b1;
          end
          // Selection sees only requests latched before this edge.
          if (i_stopStartFlag && (|pendingR)) begin
            selR   <= grantSelS;
            validR <= ONE_HOT << grantSelS;
            driveR <= 1'b1;
            stateR <= SEND;
          end
        end
        SEND: begin
          if (i_freeNext) begin
            spuriousR <= 1'b1;
          end
          cntR   <= {TO_W{1'b0}};
          stateR <= WAIT_FREE;
        end
        WAIT_FREE: begin
          if (i_freeNext) begin
            freeR  <= validR;
            validR <= {NREQ{1'b0}};
            ptrR   <= ptrNextS;
            stateR <= IDLE;
          end else begin
            cntR <= cntIncS;
            if ((TIMEOUT != 0) && (cntIncS == TO_LIM)) begin
              timeoutR <= 1'b1;
            end
          end
        end
        default: begin
          validR <= {NREQ{1'b0}};
          stateR <= IDLE;
        end
      endcase
    end
  end

  assign o_free       = freeR;
  assign o_driveNext  = driveR;
  assign o_validation = validR;
  assign o_pending    = pendingR;
  assign o_overflow   = overflowR;
  assign o_spurious   = spuriousR;
  assign o_timeout    = timeoutR;

endmodule

// File: tb/tb_arb_merge4_rr_sched.sv
// Scoreboard bench for arb_merge4_rr_sched: a rule-level reference model predicts
// every cycle's outputs; a separate monitor pops and compares them.
module tb_arb_merge4_rr_sched;
  localparam int NREQ    = 4;
  localparam int PTR_W   = 2;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic            clk = 1'b0;
  logic            w_rstStartflag = 1'b0;
  logic [NREQ-1:0] i_drive = '0;
  logic            i_freeNext = 1'b0;
  logic            i_stopStartFlag = 1'b0;
  logic [NREQ-1:0] o_free;
  logic            o_driveNext;
  logic [NREQ-1:0] o_validation;
  logic [NREQ-1:0] o_pending;
  logic            o_overflow;
  logic            o_spurious;
  logic            o_timeout;

  always #5 clk = ~clk;

  arb_merge4_rr_sched #(.NREQ(NREQ), .PTR_W(PTR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .w_rstStartflag(w_rstStartflag), .i_drive(i_drive), .o_free(o_free),
    .o_driveNext(o_driveNext), .i_freeNext(i_freeNext), .o_validation(o_validation),
    .i_stopStartFlag(i_stopStartFlag), .o_pending(o_pending), .o_overflow(o_overflow),
    .o_spurious(o_spurious), .o_timeout(o_timeout)
  );

  typedef struct {
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] free;
    logic [NREQ-1:0] valid;
    logic            drv;
    logic            ovf;
    logic            spur;
    logic            tmo;
  } expT;

  expT expQ[$];
  int  checkCnt = 0;
  int  passCnt  = 0;

  // Reference model state: plain integers and flags following the scheduling rules.
  logic [NREQ-1:0] pendM = '0;
  logic [NREQ-1:0] freeM = '0;
  int  ptrM = 0, selM = 0, gM = -10, n = 0, wcnt = 0;
  bit  busyM = 0, ovfM = 0, spurM = 0, tmoM = 0;
  logic [NREQ-1:0] curDrive = '0;
  bit  curFree = 0, curStop = 0, curRst = 0;

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pickRR();
    for (int k = 0; k < NREQ; k++) begin
      if (pendM[(ptrM + k) % NREQ]) return (ptrM + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic modelClear();
    pendM = '0; freeM = '0; ptrM = 0; busyM = 0; wcnt = 0;
    ovfM = 0; spurM = 0; tmoM = 0;
  endtask

  // Advance the model by the clock edge just passed, then queue the expected outputs.
  task automatic modelStep();
    expT e;
    logic [NREQ-1:0] clr;
    clr = '0;
    n++;
    freeM = '0;
    if (!curRst) begin
      modelClear();
    end else begin
      if (busyM) begin
        if (n == gM + 1) begin
          if (curFree) spurM = 1;
        end else if (curFree) begin
          clr[selM] = 1'b1;
          freeM = onehot(selM);
          ptrM = (selM + 1) % NREQ;
          busyM = 0;
        end else begin
          wcnt++;
          if (wcnt == TIMEOUT) tmoM = 1;
        end
      end else begin
        if (curFree) spurM = 1;
        if (curStop && pendM != '0) begin
          selM = pickRR(); busyM = 1; gM = n; wcnt = 0;
        end
      end
      if ((curDrive & pendM & ~clr) != '0) ovfM = 1;
      pendM = (pendM & ~clr) | curDrive;
    end
    e.pend  = pendM;
    e.free  = freeM;
    e.valid = busyM ? onehot(selM) : '0;
    e.drv   = busyM && (gM == n);
    e.ovf   = ovfM;
    e.spur  = spurM;
    e.tmo   = tmoM;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    modelStep();
  endtask

  task automatic apply(input logic [NREQ-1:0] d, input bit f, input bit s);
    i_drive = d; i_freeNext = f; i_stopStartFlag = s;
    curDrive = d; curFree = f; curStop = s;
  endtask

  task automatic doReset();
    @(negedge clk);
    w_rstStartflag = 1'b0; curRst = 0;
    apply('0, 1'b0, 1'b0);
    modelStep();
  endtask

  task automatic releaseRst();
    w_rstStartflag = 1'b1; curRst = 1;
  endtask

  // Acts as the shared stage; rnd=1 also randomises drives and the stop flag.
  task automatic run(input int cycles, input bit rnd, input int delay);
    logic [NREQ-1:0] d;
    bit f, s;
    for (int c = 0; c < cycles; c++) begin
      tick();
      d = '0;
      if (rnd && $urandom_range(0, 2) == 0) d = 4'($urandom) & ~pendM;
      if (rnd) f = busyM && (n >= gM + 1) && ($urandom_range(0, 2) == 0);
      else     f = busyM && (n >= gM + 1 + delay);
      s = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
      apply(d, f, s);
    end
  endtask

  task automatic cmp(input string nm, input logic [NREQ-1:0] act, input logic [NREQ-1:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  expT monE;
  // Monitor: pops one expected record per cycle, sampled just after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
        monE = expQ.pop_front();
        cmp("pending", o_pending, monE.pend);
        cmp("free", o_free, monE.free);
        cmp("validation", o_validation, monE.valid);
        cmp("driveNext", {3'b000, o_driveNext}, {3'b000, monE.drv});
        cmp("overflow", {3'b000, o_overflow}, {3'b000, monE.ovf});
        cmp("spurious", {3'b000, o_spurious}, {3'b000, monE.spur});
        cmp("timeout", {3'b000, o_timeout}, {3'b000, monE.tmo});
      end
    end
  end

  initial begin
    doReset();
    tick();
    releaseRst(); apply('0, 1'b0, 1'b1);
    // Single request on input 1, freed a few cycles after the drive.
    tick(); apply(4'b0010, 1'b0, 1'b1);
    repeat (3) begin tick(); apply('0, 1'b0, 1'b1); end
    tick(); apply('0, 1'b1, 1'b1);
    run(4, 1'b0, 0);
    // All four together, stage frees as early as possible.
    tick(); apply(4'b1111, 1'b0, 1'b1);
    run(20, 1'b0, 0);
    // Serve 2 (pointer moves to 3), then 1001 must go 3 then 0.
    tick(); apply(4'b0100, 1'b0, 1'b1);
    run(8, 1'b0, 1);
    tick(); apply(4'b1001, 1'b0, 1'b1);
    run(14, 1'b0, 0);
    // Re-drive of input 1 on its free edge, then a drive while still pending.
    tick(); apply(4'b0010, 1'b0, 1'b1);
    tick(); apply('0, 1'b0, 1'b1);
    tick(); apply('0, 1'b0, 1'b1);
    tick(); apply(4'b0010, 1'b1, 1'b1);
    tick(); apply(4'b0010, 1'b0, 1'b1);
    run(12, 1'b0, 0);
    // Free with nothing in flight, then a watchdog expiry followed by a late free.
    tick(); apply('0, 1'b1, 1'b1);
    run(3, 1'b0, 0);
    tick(); apply(4'b1000, 1'b0, 1'b1);
    run(16, 1'b0, 8);
    // Stop flag dropped mid-transaction with 0110 pending; resumes in pointer order.
    tick(); apply(4'b0001, 1'b0, 1'b1);
    tick(); apply('0, 1'b0, 1'b1);
    tick(); apply('0, 1'b0, 1'b1);
    tick(); apply(4'b0110, 1'b0, 1'b0);
    tick(); apply('0, 1'b1, 1'b0);
    repeat (6) begin tick(); apply('0, 1'b0, 1'b0); end
    run(16, 1'b0, 0);
    // Reset in the middle of WAIT_FREE; afterwards arbitration restarts at input 0.
    tick(); apply(4'b0100, 1'b0, 1'b1);
    repeat (3) begin tick(); apply('0, 1'b0, 1'b1); end
    doReset();
    tick();
    releaseRst(); apply(4'b1010, 1'b0, 1'b1);
    run(16, 1'b0, 0);
    // Randomised traffic, stage latency and stop flag.
    run(600, 1'b1, 0);
    run(20, 1'b0, 0);
    tick(); apply('0, 1'b0, 1'b1);
    #4;
    checkCnt++;
    if (expQ.size() == 0) passCnt++;
    else $display("FAIL drain: got %0d queued expected 0", expQ.size());
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
